reg_writeback_buffer: RTL and testbench

//  Write-side front end of the 32x32 register file. Accepts results from the ALU
//  and load paths, queues them in order, and drains one per cycle onto the regfile

---
 rtl/cpu_pkg.sv | 11 +
 rtl/wb_fwd_lookup.sv | 32 +++
 rtl/reg_writeback_buffer.sv | 114 +++++++++++
 tb/tb_reg_writeback_buffer.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared widths and write-back entry type
// Register-file geometry shared by the write-back queue and its forwarding lookups.
package cpu_pkg;
  localparam int REG_W  = 5;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic [REG_W-1:0]  wn;
    logic [DATA_W-1:0] d;
  } wb_entry_t;
endpackage

// File: rtl/wb_fwd_lookup.sv
// rtl/wb_fwd_lookup.sv - youngest-match forwarding lookup over pending write-backs
// Scans entries oldest to youngest from the read pointer so the last match wins.
module wb_fwd_lookup
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  wb_entry_t [DEPTH-1:0] entries_i,
  input  logic [DEPTH-1:0]      valid_i,
  input  logic [AW-1:0]         rd_ptr_i,
  input  logic [REG_W-1:0]      rn_i,
  output logic                  hit_o,
  output logic [DATA_W-1:0]     q_o
);

  logic [AW-1:0] idx;

  always_comb begin
    hit_o = 1'b0;
    q_o   = '0;
    idx   = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr_i + AW'(k);
      if (rn_i != '0 && valid_i[idx] && entries_i[idx].wn == rn_i) begin
        hit_o = 1'b1;
        q_o   = entries_i[idx].d;
      end
    end
  end

endmodule

// File: rtl/reg_writeback_buffer.sv
// rtl/reg_writeback_buffer.sv - in-order write-back queue in front of the register file
// Merges load and ALU results (load first), drains one per cycle, forwards to read ports A/B.
module reg_writeback_buffer
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic              clk,
  input  logic              clrn,
  input  logic              mem_valid,
  input  logic [REG_W-1:0]  mem_wn,
  input  logic [DATA_W-1:0] mem_d,
  output logic              mem_ready,
  input  logic              alu_valid,
  input  logic [REG_W-1:0]  alu_wn,
  input  logic [DATA_W-1:0] alu_d,
  output logic              alu_ready,
  output logic              wb_we,
  output logic [REG_W-1:0]  wb_wn,
  output logic [DATA_W-1:0] wb_d,
  input  logic [REG_W-1:0]  fa_rn,
  output logic              fa_hit,
  output logic [DATA_W-1:0] fa_q,
  input  logic [REG_W-1:0]  fb_rn,
  output logic              fb_hit,
  output logic [DATA_W-1:0] fb_q,
  output logic              empty
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  wb_entry_t [DEPTH-1:0] entries_q, entries_d;
  logic [DEPTH-1:0]      valid_q, valid_d;
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [AW:0]           count_q, count_d;
  logic [AW:0]           free;
  logic [AW-1:0]         alu_slot;
  logic                  mem_push, alu_push, pop;

  // The drain happening this cycle is deliberately not credited to free space.
  assign free      = DEPTH_C - count_q;
  assign mem_ready = free >= (AW+1)'(1);
  assign alu_ready = free >= (mem_valid ? (AW+1)'(2) : (AW+1)'(1));

  // Writes to r0 complete the handshake but are dropped.
  assign mem_push = mem_valid && mem_ready && (mem_wn != '0);
  assign alu_push = alu_valid && alu_ready && (alu_wn != '0);
  assign pop      = count_q != '0;

  always_comb begin
    entries_d = entries_q;
    valid_d   = valid_q;
    alu_slot  = wr_ptr_q + AW'(mem_push);
    if (pop) begin
      valid_d[rd_ptr_q] = 1'b0;
    end
    if (mem_push) begin
      entries_d[wr_ptr_q] = '{wn: mem_wn, d: mem_d};
      valid_d[wr_ptr_q]   = 1'b1;
    end
    if (alu_push) begin
      entries_d[alu_slot] = '{wn: alu_wn, d: alu_d};
      valid_d[alu_slot]   = 1'b1;
    end
    wr_ptr_d = wr_ptr_q + AW'({1'b0, mem_push} + {1'b0, alu_push});
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + (AW+1)'(mem_push) + (AW+1)'(alu_push) - (AW+1)'(pop);
  end

  always_ff @(posedge clk) begin
    if (!clrn) begin
      valid_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      valid_q  <= valid_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload needs no reset: it is only observed through valid bits and count.
  always_ff @(posedge clk) begin
    entries_q <= entries_d;
  end

  assign wb_we = pop;
  assign wb_wn = pop ? entries_q[rd_ptr_q].wn : '0;
  assign wb_d  = pop ? entries_q[rd_ptr_q].d  : '0;
  assign empty = count_q == '0;

  wb_fwd_lookup #(.DEPTH(DEPTH), .AW(AW)) u_fwd_a (
    .entries_i (entries_q),
    .valid_i   (valid_q),
    .rd_ptr_i  (rd_ptr_q),
    .rn_i      (fa_rn),
    .hit_o     (fa_hit),
    .q_o       (fa_q)
  );

  wb_fwd_lookup #(.DEPTH(DEPTH), .AW(AW)) u_fwd_b (
    .entries_i (entries_q),
    .valid_i   (valid_q),
    .rd_ptr_i  (rd_ptr_q),
    .rn_i      (fb_rn),
    .hit_o     (fb_hit),
    .q_o       (fb_q)
  );

endmodule

// File: tb/tb_reg_writeback_buffer.sv
// tb/tb_reg_writeback_buffer.sv - self-checking bench for reg_writeback_buffer
// A queue of pending writes predicts drain order, ready and forwarding results.
module tb_reg_writeback_buffer;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        clrn;
  logic        mem_valid, alu_valid;
  logic [4:0]  mem_wn, alu_wn, fa_rn, fb_rn;
  logic [31:0] mem_d, alu_d;
  logic        mem_ready, alu_ready, wb_we, fa_hit, fb_hit, empty;
  logic [4:0]  wb_wn;
  logic [31:0] wb_d, fa_q, fb_q;

  always #5 clk = ~clk;

  reg_writeback_buffer dut (
    .clk(clk), .clrn(clrn),
    .mem_valid(mem_valid), .mem_wn(mem_wn), .mem_d(mem_d), .mem_ready(mem_ready),
    .alu_valid(alu_valid), .alu_wn(alu_wn), .alu_d(alu_d), .alu_ready(alu_ready),
    .wb_we(wb_we), .wb_wn(wb_wn), .wb_d(wb_d),
    .fa_rn(fa_rn), .fa_hit(fa_hit), .fa_q(fa_q),
    .fb_rn(fb_rn), .fb_hit(fb_hit), .fb_q(fb_q),
    .empty(empty)
  );

  typedef struct {
    logic        mv;
    logic [4:0]  mwn;
    logic [31:0] md;
    logic        av;
    logic [4:0]  awn;
    logic [31:0] ad;
    logic [4:0]  rna;
    logic [4:0]  rnb;
    logic        exp_mrdy;
    logic        exp_ardy;
  } vec_t;

  vec_t      vecs [9];
  wb_entry_t pend [$];
  int        checks   = 0;
  int        failures = 0;
  int        cur_c;
  logic      cur_em, cur_ea;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic model_fwd(input logic [4:0] rn, output logic hit, output logic [31:0] q);
    hit = 1'b0;
    q   = '0;
    for (int i = 0; i < pend.size(); i++) begin
      if (rn != 5'd0 && pend[i].wn == rn) begin
        hit = 1'b1;
        q   = pend[i].d;
      end
    end
  endtask

  // Called one time unit after a rising edge; checks land before the next edge.
  task automatic drive_check(input logic mv, input logic [4:0] mwn, input logic [31:0] md,
                             input logic av, input logic [4:0] awn, input logic [31:0] ad,
                             input logic [4:0] rna, input logic [4:0] rnb);
    logic        eh;
    logic [31:0] eq;
    mem_valid = mv; mem_wn = mwn; mem_d = md;
    alu_valid = av; alu_wn = awn; alu_d = ad;
    fa_rn = rna; fb_rn = rnb;
    #2;
    cur_c  = pend.size();
    cur_em = (4 - cur_c) >= 1;
    cur_ea = (4 - cur_c) >= (mv ? 2 : 1);
    chk("mem_ready", mem_ready, cur_em);
    chk("alu_ready", alu_ready, cur_ea);
    chk("empty", empty, cur_c == 0);
    if (cur_c > 0) begin
      chk("wb_we", wb_we, 1);
      chk("wb_wn", wb_wn, pend[0].wn);
      chk("wb_d", wb_d, pend[0].d);
    end else begin
      chk("wb_we_idle", wb_we, 0);
      chk("wb_wn_idle", wb_wn, 0);
      chk("wb_d_idle", wb_d, 0);
    end
    model_fwd(rna, eh, eq);
    chk("fa_hit", fa_hit, eh);
    chk("fa_q", fa_q, eq);
    model_fwd(rnb, eh, eq);
    chk("fb_hit", fb_hit, eh);
    chk("fb_q", fb_q, eq);
  endtask

  task automatic clock_edge();
    wb_entry_t tmp;
    @(posedge clk);
    if (cur_c > 0) tmp = pend.pop_front();
    if (mem_valid && cur_em && mem_wn != 5'd0) pend.push_back('{wn: mem_wn, d: mem_d});
    if (alu_valid && cur_ea && alu_wn != 5'd0) pend.push_back('{wn: alu_wn, d: alu_d});
    #1;
  endtask

  task automatic cycle(input logic mv, input logic [4:0] mwn, input logic [31:0] md,
                       input logic av, input logic [4:0] awn, input logic [31:0] ad,
                       input logic [4:0] rna, input logic [4:0] rnb);
    drive_check(mv, mwn, md, av, awn, ad, rna, rnb);
    clock_edge();
  endtask

  task automatic do_reset(input logic [4:0] rna, input logic [4:0] rnb);
    clrn = 1'b0;
    mem_valid = 1'b0; mem_wn = '0; mem_d = '0;
    alu_valid = 1'b0; alu_wn = '0; alu_d = '0;
    fa_rn = rna; fb_rn = rnb;
    @(posedge clk);
    #1;
    clrn = 1'b1;
    pend.delete();
    #2;
    chk("rst_wb_we", wb_we, 0);
    chk("rst_wb_wn", wb_wn, 0);
    chk("rst_wb_d", wb_d, 0);
    chk("rst_empty", empty, 1);
    chk("rst_mem_ready", mem_ready, 1);
    chk("rst_alu_ready", alu_ready, 1);
    chk("rst_fa_hit", fa_hit, 0);
    chk("rst_fa_q", fa_q, 0);
    chk("rst_fb_hit", fb_hit, 0);
    chk("rst_fb_q", fb_q, 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0] = '{1'b1, 5'd1, 32'h0000_0011, 1'b1, 5'd2, 32'h0000_0022, 5'd1, 5'd2, 1'b1, 1'b1};
    vecs[1] = '{1'b1, 5'd3, 32'h0000_0033, 1'b1, 5'd4, 32'h0000_0044, 5'd2, 5'd3, 1'b1, 1'b1};
    vecs[2] = '{1'b1, 5'd5, 32'h0000_0055, 1'b1, 5'd6, 32'h0000_0066, 5'd3, 5'd5, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 5'd7, 32'h0000_0077, 1'b1, 5'd8, 32'h0000_0088, 5'd5, 5'd6, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 5'd0, 32'h0,         1'b1, 5'd9, 32'h0000_0099, 5'd7, 5'd8, 1'b1, 1'b1};
    vecs[5] = '{1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 32'h0,         5'd9, 5'd5, 1'b1, 1'b1};
    vecs[6] = '{1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd9, 1'b1, 1'b1};
    vecs[7] = '{1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 32'h0,         5'd9, 5'd0, 1'b1, 1'b1};
    vecs[8] = '{1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 32'h0,         5'd1, 5'd9, 1'b1, 1'b1};

    do_reset(5'd0, 5'd0);

    // Single ALU write: visible one cycle later, gone after the write edge.
    cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 32'h1234, 5'd3, 5'd0);
    chk("t2_wb_we", wb_we, 1);
    chk("t2_wb_wn", wb_wn, 3);
    chk("t2_wb_d", wb_d, 32'h1234);
    chk("t2_fa_hit", fa_hit, 1);
    chk("t2_fa_q", fa_q, 32'h1234);
    cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd3, 5'd3);
    chk("t2_empty", empty, 1);
    chk("t2_fa_hit_after", fa_hit, 0);

    // Same register from both sources: load drains first, ALU value forwarded.
    cycle(1'b1, 5'd5, 32'hAAAA_0001, 1'b1, 5'd5, 32'hBBBB_0002, 5'd5, 5'd5);
    chk("t3_fa_q_young", fa_q, 32'hBBBB_0002);
    chk("t3_wb_d_first", wb_d, 32'hAAAA_0001);
    cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
    chk("t3_wb_d_second", wb_d, 32'hBBBB_0002);
    chk("t3_fb_q", fb_q, 32'hBBBB_0002);
    cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd5);

    // Write to r0 is accepted and discarded.
    cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
    chk("t5_wb_we", wb_we, 0);
    chk("t5_empty", empty, 1);
    chk("t5_fa_hit", fa_hit, 0);
    chk("t5_fa_q", fa_q, 0);

    // Fill and drain from the vector table.
    for (int i = 0; i < 9; i++) begin
      drive_check(vecs[i].mv, vecs[i].mwn, vecs[i].md, vecs[i].av, vecs[i].awn, vecs[i].ad,
                  vecs[i].rna, vecs[i].rnb);
      chk($sformatf("tbl%0d_mem_ready", i), mem_ready, vecs[i].exp_mrdy);
      chk($sformatf("tbl%0d_alu_ready", i), alu_ready, vecs[i].exp_ardy);
      clock_edge();
    end

    // Reset with three entries pending discards them.
    cycle(1'b1, 5'd1, 32'h0000_1001, 1'b1, 5'd2, 32'h0000_2002, 5'd0, 5'd0);
    cycle(1'b1, 5'd3, 32'h0000_3003, 1'b1, 5'd4, 32'h0000_4004, 5'd0, 5'd0);
    chk("t6_pending", pend.size(), 3);
    do_reset(5'd3, 5'd4);
    cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd2, 5'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
